// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board stage: cell/game encodings,
// the win-line table, the board FSM state type and a line-detect helper.
package ttt_pkg;

  localparam int unsigned CELL_W  = 2;
  localparam int unsigned LOC_W   = 4;
  localparam int unsigned N_CELLS = 9;
  localparam int unsigned N_LINES = 8;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [N_CELLS-1:0] board_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_X     = 2'b10;
  localparam cell_t CELL_O     = 2'b01;

  localparam logic [1:0] GAME_RUN  = 2'b00;
  localparam logic [1:0] GAME_XWIN = 2'b10;
  localparam logic [1:0] GAME_OWIN = 2'b01;

  localparam logic [LOC_W-1:0] LOC_NONE = 4'hF;

  // Entry 0 is the last literal: rows, then columns, then the two diagonals.
  localparam logic [N_LINES-1:0][2:0][LOC_W-1:0] WIN_LINES = {
    12'h246, 12'h048,
    12'h258, 12'h147, 12'h036,
    12'h678, 12'h345, 12'h012
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CHECK  = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // True when player p owns all three cells of any win line.
  function automatic logic line_won(input board_t b, input cell_t p);
    logic won;
    won = 1'b0;
    for (int i = 0; i < int'(N_LINES); i++) begin
      if (b[WIN_LINES[i][0]] == p && b[WIN_LINES[i][1]] == p &&
          b[WIN_LINES[i][2]] == p) begin
        won = 1'b1;
      end
    end
    return won;
  endfunction

endpackage

// File: rtl/board_keeper_mark_fifo.sv
// mark_fifo: per-player ring of board locations in placement order.
// Ports: clk, rst (async, active high), push/din append a location,
// pop drops the oldest, head = oldest location, full = holds MAX_MARKS,
// count = number of entries (0..MAX_MARKS). Push and pop may coincide.
module mark_fifo
  import ttt_pkg::*;
#(
  parameter int unsigned MAX_MARKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] din,
  output logic [LOC_W-1:0] head,
  output logic             full,
  output logic [2:0]       count
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic [LOC_W-1:0] mem_q [MAX_MARKS];
  logic [LOC_W-1:0] mem_d [MAX_MARKS];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointer increment with modulo-MAX_MARKS wrap.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_MARKS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_next(wr_q);
    end
    if (pop) begin
      rd_d = ptr_next(rd_q);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_MARKS); i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CNT_W'(MAX_MARKS));
  assign count = cnt_q;

endmodule

// File: rtl/board_keeper.sv
// board_keeper: keeps the 3x3 board from committed moves, enforces the
// "at most MAX_MARKS marks per player, oldest vanishes" rule and flags wins.
// Ports: clk, rst (async, active high), location/mark = held move from the
// input stage; a0..a8 = cell contents (00 empty, 10 X, 01 O); gameend =
// 00 running / 10 X won / 01 O won.
// Optional GHOST_PREVIEW_EN adds next_vanish: the cell the next mover will
// lose on their next placement, or 4'hF when that player's ring is not full.
module board_keeper
  import ttt_pkg::*;
#(
  parameter int unsigned MAX_MARKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] location,
  input  logic [1:0] mark,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] gameend
`ifdef GHOST_PREVIEW_EN
  ,
  output logic [3:0] next_vanish
`endif
);

  state_t           state_q, state_d;
  board_t           cells_q, cells_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  cell_t            player_q, player_d;
  logic [1:0]       gameend_q, gameend_d;

  logic             push_x_c, pop_x_c, push_o_c, pop_o_c;
  logic [LOC_W-1:0] head_x, head_o;
  logic             full_x, full_o;
  logic [2:0]       count_x, count_o;
  logic [LOC_W-1:0] loc_idx_c;
  logic             accept_c;

`ifdef GHOST_PREVIEW_EN
  logic [LOC_W-1:0] next_vanish_q, next_vanish_d;
`endif

  mark_fifo #(.MAX_MARKS(MAX_MARKS)) u_fifo_x (
    .clk   (clk),
    .rst   (rst),
    .push  (push_x_c),
    .pop   (pop_x_c),
    .din   (loc_q),
    .head  (head_x),
    .full  (full_x),
    .count (count_x)
  );

  mark_fifo #(.MAX_MARKS(MAX_MARKS)) u_fifo_o (
    .clk   (clk),
    .rst   (rst),
    .push  (push_o_c),
    .pop   (pop_o_c),
    .din   (loc_q),
    .head  (head_o),
    .full  (full_o),
    .count (count_o)
  );

  // The held level never re-fires because the target cell is no longer empty.
  always_comb begin
    loc_idx_c = (location <= LOC_W'(N_CELLS - 1)) ? location : '0;
    accept_c  = (mark == CELL_X || mark == CELL_O) &&
                (location <= LOC_W'(N_CELLS - 1)) &&
                (cells_q[loc_idx_c] == CELL_EMPTY) &&
                (gameend_q == GAME_RUN);
  end

  // Board FSM: next state, board update and ring control.
  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    loc_d     = loc_q;
    player_d  = player_q;
    gameend_d = gameend_q;
    push_x_c  = 1'b0;
    pop_x_c   = 1'b0;
    push_o_c  = 1'b0;
    pop_o_c   = 1'b0;
`ifdef GHOST_PREVIEW_EN
    next_vanish_d = next_vanish_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          loc_d    = location;
          player_d = mark;
          state_d  = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Eviction clears first; the new mark is written last so it always lands.
        if (player_q == CELL_X) begin
          push_x_c = 1'b1;
          if (full_x && count_x != '0) begin
            pop_x_c         = 1'b1;
            cells_d[head_x] = CELL_EMPTY;
          end
        end else begin
          push_o_c = 1'b1;
          if (full_o && count_o != '0) begin
            pop_o_c         = 1'b1;
            cells_d[head_o] = CELL_EMPTY;
          end
        end
        cells_d[loc_q] = player_q;
        state_d        = ST_CHECK;
      end
      ST_CHECK: begin
        // Board is already post-eviction here; only the mover can have won.
        if (line_won(cells_q, player_q)) begin
          gameend_d = player_q;
          state_d   = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef GHOST_PREVIEW_EN
        if (player_q == CELL_X) begin
          next_vanish_d = full_o ? head_o : LOC_NONE;
        end else begin
          next_vanish_d = full_x ? head_x : LOC_NONE;
        end
`endif
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cells_q   <= '0;
      loc_q     <= '0;
      player_q  <= CELL_EMPTY;
      gameend_q <= GAME_RUN;
`ifdef GHOST_PREVIEW_EN
      next_vanish_q <= LOC_NONE;
`endif
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      loc_q     <= loc_d;
      player_q  <= player_d;
      gameend_q <= gameend_d;
`ifdef GHOST_PREVIEW_EN
      next_vanish_q <= next_vanish_d;
`endif
    end
  end

  assign a0      = cells_q[0];
  assign a1      = cells_q[1];
  assign a2      = cells_q[2];
  assign a3      = cells_q[3];
  assign a4      = cells_q[4];
  assign a5      = cells_q[5];
  assign a6      = cells_q[6];
  assign a7      = cells_q[7];
  assign a8      = cells_q[8];
  assign gameend = gameend_q;
`ifdef GHOST_PREVIEW_EN
  assign next_vanish = next_vanish_q;
`endif

endmodule
